// File: rtl/solid_scan_pkg.sv
// Shared types and default geometry for the solid-map box scanner.
package solid_scan_pkg;

  localparam int unsigned DEF_MAP_W      = 128;
  localparam int unsigned DEF_MAP_H      = 128;
  localparam int unsigned DEF_TILE_SHIFT = 3;
  localparam int unsigned DEF_COORD_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

  typedef struct packed {
    logic signed [DEF_COORD_W-1:0] x;
    logic signed [DEF_COORD_W-1:0] y;
    logic        [7:0]             w;
    logic        [7:0]             h;
  } scan_req_t;

  typedef struct packed {
    logic [$clog2(DEF_MAP_W)-1:0] tx;
    logic [$clog2(DEF_MAP_H)-1:0] ty;
  } tile_coord_t;

  function automatic logic box_empty(input logic [7:0] w, input logic [7:0] h);
    return (w == 8'd0) || (h == 8'd0);
  endfunction

endpackage

// File: rtl/solid_scan_range.sv
// One axis of a pixel box converted to an inclusive, map-clamped tile range.
module solid_scan_range #(
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned DIM        = 128,
  parameter int unsigned TILE_SHIFT = 3,
  parameter int unsigned TW         = $clog2(DIM)
) (
  input  logic signed [COORD_W-1:0] i_org,
  input  logic        [7:0]         i_size,
  output logic        [TW-1:0]      o_lo,
  output logic        [TW-1:0]      o_hi
);

  localparam logic signed [COORD_W:0] TMAX = (COORD_W+1)'(DIM - 1);

  logic signed [COORD_W:0] w_org;
  logic signed [COORD_W:0] w_size;
  logic signed [COORD_W:0] w_end;

  assign w_org  = {i_org[COORD_W-1], i_org};
  assign w_size = {{(COORD_W-7){1'b0}}, i_size};
  assign w_end  = w_org + w_size - (COORD_W+1)'(1);

  function automatic logic [TW-1:0] clamp_tile(input logic signed [COORD_W:0] t);
    if (t < 0)
      clamp_tile = '0;
    else if (t > TMAX)
      clamp_tile = TW'(DIM - 1);
    else
      clamp_tile = t[TW-1:0];
  endfunction

  assign o_lo = clamp_tile(w_org >>> TILE_SHIFT);
  assign o_hi = clamp_tile(w_end >>> TILE_SHIFT);

endmodule

// File: rtl/solid_scan.sv
// Walks every map tile under a pixel hitbox and reports the first solid one.
// Optional SOLID_SCAN_COUNT_EN: full scan with a solid-tile count instead of early exit.
module solid_scan
  import solid_scan_pkg::*;
#(
  parameter int unsigned MAP_W      = DEF_MAP_W,
  parameter int unsigned MAP_H      = DEF_MAP_H,
  parameter int unsigned TILE_SHIFT = DEF_TILE_SHIFT,
  parameter int unsigned COORD_W    = DEF_COORD_W,
  parameter int unsigned TXW        = $clog2(MAP_W),
  parameter int unsigned TYW        = $clog2(MAP_H),
  parameter int unsigned AW         = TXW + TYW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic signed [COORD_W-1:0] req_x,
  input  logic signed [COORD_W-1:0] req_y,
  input  logic        [7:0]         req_w,
  input  logic        [7:0]         req_h,
  output logic                      map_rd_en,
  output logic        [AW-1:0]      map_addr,
  input  logic                      map_rd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_hit,
  output logic        [TXW-1:0]     rsp_tx,
  output logic        [TYW-1:0]     rsp_ty
`ifdef SOLID_SCAN_COUNT_EN
  ,
  output logic        [AW:0]        rsp_count
`endif
);

  scan_state_t r_state, w_next;

  logic signed [COORD_W-1:0] r_x, r_y;
  logic        [7:0]         r_w, r_h;
  logic        [TXW-1:0]     r_tx0, r_tx1, r_tx, r_ptx, r_htx;
  logic        [TYW-1:0]     r_ty1, r_ty, r_pty, r_hty;
  logic                      r_pend, r_hit;
  logic        [TXW-1:0]     w_tx0, w_tx1;
  logic        [TYW-1:0]     w_ty0, w_ty1;
  logic                      w_eval_hit, w_last, w_stop;

  solid_scan_range #(.COORD_W(COORD_W), .DIM(MAP_W), .TILE_SHIFT(TILE_SHIFT)) u_range_x (
    .i_org(r_x), .i_size(r_w), .o_lo(w_tx0), .o_hi(w_tx1)
  );

  solid_scan_range #(.COORD_W(COORD_W), .DIM(MAP_H), .TILE_SHIFT(TILE_SHIFT)) u_range_y (
    .i_org(r_y), .i_size(r_h), .o_lo(w_ty0), .o_hi(w_ty1)
  );

  // r_pend marks a read issued last cycle whose data is on map_rd_data now.
  assign w_eval_hit = r_pend && map_rd_data && (r_state == ST_SCAN || r_state == ST_DRAIN);
  assign w_last     = (r_tx == r_tx1) && (r_ty == r_ty1);

`ifdef SOLID_SCAN_COUNT_EN
  logic [AW:0] r_count;
  assign w_stop    = 1'b0;
  assign rsp_count = r_count;
`else
  assign w_stop    = w_eval_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_next = box_empty(req_w, req_h) ? ST_DONE : ST_SETUP;
      ST_SETUP: w_next = ST_SCAN;
      ST_SCAN:  if (w_stop) w_next = ST_DONE;
                else if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    map_rd_en = (r_state == ST_SCAN);
    rsp_valid = (r_state == ST_DONE);
  end

  assign map_addr = {r_ty, r_tx};
  assign rsp_hit  = r_hit;
  assign rsp_tx   = r_htx;
  assign rsp_ty   = r_hty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0; r_y <= '0; r_w <= '0; r_h <= '0;
      r_tx0 <= '0; r_tx1 <= '0; r_ty1 <= '0;
      r_tx <= '0; r_ty <= '0; r_ptx <= '0; r_pty <= '0;
      r_pend <= 1'b0; r_hit <= 1'b0; r_htx <= '0; r_hty <= '0;
`ifdef SOLID_SCAN_COUNT_EN
      r_count <= '0;
`endif
    end else begin
      r_pend <= 1'b0;
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_x <= req_x; r_y <= req_y; r_w <= req_w; r_h <= req_h;
          r_hit <= 1'b0; r_htx <= '0; r_hty <= '0;
`ifdef SOLID_SCAN_COUNT_EN
          r_count <= '0;
`endif
        end
        ST_SETUP: begin
          r_tx0 <= w_tx0; r_tx1 <= w_tx1; r_ty1 <= w_ty1;
          r_tx  <= w_tx0; r_ty  <= w_ty0;
        end
        ST_SCAN: begin
          r_pend <= 1'b1;
          r_ptx  <= r_tx;
          r_pty  <= r_ty;
          if (!w_last) begin
            if (r_tx == r_tx1) begin
              r_tx <= r_tx0;
              r_ty <= r_ty + 1'b1;
            end else begin
              r_tx <= r_tx + 1'b1;
            end
          end
        end
        default: ;
      endcase
      if (w_eval_hit) begin
`ifdef SOLID_SCAN_COUNT_EN
        r_count <= r_count + (AW+1)'(1);
`endif
        if (!r_hit) begin
          r_hit <= 1'b1;
          r_htx <= r_ptx;
          r_hty <= r_pty;
        end
      end
    end
  end

endmodule

// File: doc/solid_scan.md
# solid_scan

Sequential collision scanner for the tile map: accepts a pixel-space hitbox, walks every map tile the box overlaps in row-major order, and reports whether any is solid, plus the first solid tile's coordinates. It generalises the single-point solid lookup to arbitrary boxes and parametrised map/tile sizes. It sits between player/object physics and the synchronous solid-map RAM.

## Interface
- MAP_W, 128, map width in tiles (power of two)
- MAP_H, 128, map height in tiles (power of two)
- TILE_SHIFT, 3, log2 tile size in pixels
- COORD_W, 16, signed pixel coordinate width
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_x, req_y  in  COORD_W each  signed box origin, pixels
- req_w, req_h  in  8 each  unsigned box size, pixels
- map_rd_en  out  1  map read strobe
- map_addr  out  log2(MAP_W*MAP_H)  {ty, tx}
- map_rd_data  in  1  solid bit, valid the cycle after map_rd_en
- rsp_valid  out  1  result held until accepted
- rsp_ready  in  1  consumer accepts result
- rsp_hit  out  1  any overlapped tile solid
- rsp_tx, rsp_ty  out  log2(MAP_W), log2(MAP_H)  first solid tile (row-major); 0 when no hit
- rsp_count  out  log2(MAP_W*MAP_H)+1  solid-tile count (only with SOLID_SCAN_COUNT_EN)

## Operation
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE: req_ready=1; req_valid&&req_ready latches request -> SETUP (or -> DONE with rsp_hit=0 if req_w==0 or req_h==0).
- SETUP: tx0=req_x>>>TILE_SHIFT, tx1=(req_x+req_w-1)>>>TILE_SHIFT, same for y; sums in COORD_W+1 signed; arithmetic shift. Each bound clamped to [0, MAP_W-1] / [0, MAP_H-1] (negative -> 0). -> SCAN.
- SCAN: one read per cycle, tx inner loop tx0..tx1, ty outer loop ty0..ty1. map_rd_data is evaluated the cycle after its read. First solid result latches rsp_tx/rsp_ty, sets rsp_hit, -> DONE; the one read already issued is discarded. After the last address is issued -> DRAIN.
- DRAIN: evaluates final read -> DONE.
- DONE: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready -> IDLE. New requests are not accepted in the same cycle.
- Boxes wholly off-map clamp onto edge tiles (matches single-point lookup semantics).

## Timing
- Reset values: req_ready=1 (on deassertion, IDLE), rsp_valid=0, rsp_hit=0, rsp_tx=rsp_ty=0, rsp_count=0, map_rd_en=0, map_addr=0.
- Reset asserted mid-scan: immediate return to IDLE, outstanding read ignored.
- Accept at cycle 0; SETUP cycle 1; reads issued cycles 2..N+1 (N = tile count).
- Miss: rsp_valid at cycle N+3. Hit on tile index i (0-based): rsp_valid at cycle i+4.
- Empty box: rsp_valid at cycle 1.
- map_rd_en high only in SCAN.

## Configuration
- SOLID_SCAN_COUNT_EN defined: no early exit; all N tiles scanned, rsp_count = solid tiles, rsp_tx/ty = first hit; rsp_valid always at N+3.
- Undefined: early exit as above; rsp_count port absent.

## Structure
- Shared package: scan_req_t struct {x, y, w, h}, tile_coord_t {tx, ty}, SCAN state enum, default MAP_W/MAP_H/TILE_SHIFT constants.
- Sub-module solid_scan_range: combinational box-to-clamped-tile-range computation, instantiated once for x and once for y.

## Test plan
- Box (16,16,8,8), tile (2,2) solid -> N=1, rsp_hit=1, rsp_tx=2, rsp_ty=2, rsp_valid at cycle 4.
- Box (16,16,16,16) empty map -> 4 reads in order (2,2),(3,2),(2,3),(3,3), rsp_hit=0 at cycle 7.
- Same box, only (3,3) and (3,2) solid -> hit at (3,2), rsp_valid cycle 5; with COUNT_EN rsp_count=2 at cycle 7.
- Box (-20,-4,8,8) -> clamped to tile (0,0), single read, addr 0.
- Box w=0 -> no reads, rsp_valid cycle 1, rsp_hit=0; hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
- rst_n low during SCAN cycle 3 -> rsp_valid=0, map_rd_en=0 same cycle; next request completes normally.
